interval_meter: RTL
===================

INTERVAL_METER -- requirements
Module: interval_meter

Interface
REQ-001 Parameter WIDTH, default 10: width of the elapsed-seconds count; the count saturates at 2^WIDTH-1 (1023).
REQ-002 Parameter T5, default 300: lower bound in seconds of band 1 (5 minutes).
REQ-003 Parameter T7, default 420: lower bound in seconds of band 2 (7 minutes).
REQ-004 Parameter T8, default 480: lower bound in seconds of band 3 (8 minutes).
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 tick  input  1  one-cycle strobe marking one elapsed second.
REQ-008 start  input  1  level sampled each cycle; begins or restarts a measurement.
REQ-009 stop  input  1  level sampled each cycle; ends the current measurement.
REQ-010 elapsedSeconds  output  WIDTH  registered result of the last completed measurement.
REQ-011 band  output  2  registered class of elapsedSeconds: 0 <T5, 1 T5..T7-1, 2 T7..T8-1, 3 >=T8.
REQ-012 done  output  1  one-cycle pulse; elapsedSeconds/band/overflow updated this cycle.
REQ-013 busy  output  1  high while a measurement is running.
REQ-014 overflow  output  1  high when the count saturated during the reported measurement.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-016 In IDLE: start=1 -> RUN, internal count cleared to 0 and run-overflow flag cleared on the same edge; stop and tick ignored.
REQ-017 In RUN: busy=1; each cycle with tick=1 the count SHALL increment by 1, WIDTH-bit unsigned.
REQ-018 Saturation: tick at count 2^WIDTH-1 SHALL leave count at 2^WIDTH-1 and set the run-overflow flag; no wrap to 0.
REQ-019 In RUN: stop=1 -> DONE; the value latched SHALL include a tick in that same cycle (count+1, saturating).
REQ-020 In RUN: start=1 with stop=0 SHALL restart: count <- 0, run-overflow flag cleared, stay in RUN, no done pulse.
REQ-021 In RUN: start=1 and stop=1 in the same cycle SHALL be treated as stop; start ignored.
REQ-022 On the RUN->DONE edge elapsedSeconds, band and overflow SHALL be loaded so they are valid in the cycle done=1.
REQ-023 DONE lasts exactly one cycle with done=1, busy=0; then -> IDLE, or -> RUN (count cleared) if start=1 in DONE.
REQ-024 elapsedSeconds, band, overflow SHALL hold their values between done pulses, including across later RUN periods.
REQ-025 band SHALL be computed from the same value loaded into elapsedSeconds, with >= comparisons at T5, T7, T8.
REQ-026 done SHALL never be high in two consecutive cycles; busy and done SHALL never be high together.
REQ-027 Latency: done is asserted 1 cycle after the cycle where stop is sampled in RUN.

Reset
REQ-028 reset=1 SHALL on the next edge force IDLE, internal count 0, run-overflow flag 0, elapsedSeconds 0, band 0, done 0, busy 0, overflow 0.
REQ-029 reset SHALL take priority over start, stop and tick, including mid-RUN and during DONE; no done pulse is generated.
REQ-030 After reset deassertion the block SHALL accept start on the first following cycle.

Verification
REQ-031 start, 300 ticks, stop (no tick that cycle) -> next cycle done=1, elapsedSeconds=300, band=1, overflow=0.
REQ-032 start, 479 ticks, stop with tick in same cycle -> elapsedSeconds=480, band=3; repeat with 419 ticks+stop-no-tick -> 419, band=1.
REQ-033 start, 1100 ticks, stop -> elapsedSeconds=1023, band=3, overflow=1; following run of 5 ticks -> 5, band=0, overflow=0.
REQ-034 start, 100 ticks, start again, 50 ticks, stop -> single done pulse, elapsedSeconds=50; start+stop same cycle in RUN -> done, value=count.
REQ-035 start, 200 ticks, reset mid-RUN, then stop -> no done, all outputs 0, busy=0; stop/tick in IDLE -> no state change.
REQ-036 start asserted in the DONE cycle -> busy=1 next cycle, prior elapsedSeconds held until the next done.

Source files
------------

// File: rtl/interval_meter.sv
// interval_meter: measures the number of one-second ticks between start and stop.
// The count saturates at 2^WIDTH-1 instead of wrapping. Each completed
// measurement is published together with a duration band and an overflow flag,
// and done pulses for one cycle when they change.
module interval_meter #(
    parameter int WIDTH = 10,
    parameter int T5    = 300,
    parameter int T7    = 420,
    parameter int T8    = 480
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] elapsedSeconds,
    output logic [1:0]       band,
    output logic             done,
    output logic             busy,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] L_MAX = '1;
    localparam logic [WIDTH-1:0] L_T5  = WIDTH'(T5);
    localparam logic [WIDTH-1:0] L_T7  = WIDTH'(T7);
    localparam logic [WIDTH-1:0] L_T8  = WIDTH'(T8);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_run_ovf;
    logic [WIDTH-1:0] r_elapsed;
    logic [1:0]       r_band;
    logic             r_done;
    logic             r_busy;
    logic             r_overflow;

    logic             w_sat_hit;
    logic [WIDTH-1:0] w_count_next;
    logic             w_ovf_next;

    // Classify a measured duration; the bounds are inclusive lower limits.
    function automatic logic [1:0] band_of(input logic [WIDTH-1:0] v);
        logic [1:0] b;
        if (v >= L_T8)      b = 2'd3;
        else if (v >= L_T7) b = 2'd2;
        else if (v >= L_T5) b = 2'd1;
        else                b = 2'd0;
        return b;
    endfunction

    // Count after this cycle's tick, saturating at the top instead of wrapping.
    always_comb begin
        w_sat_hit    = tick && (r_count == L_MAX);
        w_count_next = r_count;
        if (tick && (r_count != L_MAX)) begin
            w_count_next = r_count + 1'b1;
        end
        w_ovf_next   = r_run_ovf | w_sat_hit;
    end

    // Measurement FSM; every output is a register loaded here.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_run_ovf  <= 1'b0;
            r_elapsed  <= '0;
            r_band     <= 2'd0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state   <= S_RUN;
                        r_count   <= '0;
                        r_run_ovf <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        // A tick arriving with stop still counts toward the result.
                        r_state    <= S_DONE;
                        r_elapsed  <= w_count_next;
                        r_band     <= band_of(w_count_next);
                        r_overflow <= w_ovf_next;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                    end else if (start) begin
                        r_count   <= '0;
                        r_run_ovf <= 1'b0;
                    end else begin
                        r_count   <= w_count_next;
                        r_run_ovf <= w_ovf_next;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state   <= S_RUN;
                        r_count   <= '0;
                        r_run_ovf <= 1'b0;
                        r_busy    <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign elapsedSeconds = r_elapsed;
    assign band           = r_band;
    assign done           = r_done;
    assign busy           = r_busy;
    assign overflow       = r_overflow;

endmodule
